// File: rtl/ctech_lib_clk_gate_seq.sv
// Clock-gate enable sequencer: gates clk after IDLE_CYC+1 qualified idle edges, re-enables on wake/force/~idle, clk_on after WAKE_CYC settle cycles.
// All outputs registered (1-edge latency); wake_req is a level handshake held until clk_on; CTECH_CLK_GATE_SEQ_TEST_OVRD_EN adds test_ovrd.
module ctech_lib_clk_gate_seq #(
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 4,
  localparam int CNT_W = $clog2(((IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC) + 1)
) (
  input  logic clk,
  input  logic rst_b,
  input  logic idle,
  input  logic wake_req,
  input  logic force_on,
`ifdef CTECH_CLK_GATE_SEQ_TEST_OVRD_EN
  input  logic test_ovrd,
`endif
  output logic clken,
  output logic clk_on,
  output logic gated
);

  generate
    if (IDLE_CYC < 1 || WAKE_CYC < 1) begin : g_bad_cfg
      $fatal(1, "ctech_lib_clk_gate_seq: IDLE_CYC and WAKE_CYC must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_ON        = 2'd0,
    ST_IDLE_WAIT = 2'd1,
    ST_OFF       = 2'd2,
    ST_WAKE      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             clken_q, clk_on_q, gated_q;
  logic             clken_nx, clk_on_nx, gated_nx;
  logic             ovrd;
  logic             qual;

`ifdef CTECH_CLK_GATE_SEQ_TEST_OVRD_EN
  assign ovrd = test_ovrd;
`else
  assign ovrd = 1'b0;
`endif

  // Scan override acts as an extra force_on so the FSM cannot start gating.
  assign qual = idle & ~wake_req & ~force_on & ~ovrd;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_ON: begin
        if (qual) begin
          state_nx = ST_IDLE_WAIT;
          cnt_nx   = '0;
        end
      end
      ST_IDLE_WAIT: begin
        if (!qual) begin
          state_nx = ST_ON;
          cnt_nx   = '0;
        end else if (cnt == IDLE_LAST) begin
          state_nx = ST_OFF;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (!qual) begin
          state_nx = ST_WAKE;
          cnt_nx   = '0;
        end
      end
      ST_WAKE: begin
        // Inputs ignored: a started wake always completes.
        if (cnt == WAKE_LAST) begin
          state_nx = ST_ON;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_ON;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    clken_nx  = (state_nx != ST_OFF);
    clk_on_nx = (state_nx == ST_ON) || (state_nx == ST_IDLE_WAIT);
    gated_nx  = (state_nx == ST_OFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= ST_ON;
      cnt      <= '0;
      clken_q  <= 1'b1;
      clk_on_q <= 1'b1;
      gated_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      clken_q  <= clken_nx;
      clk_on_q <= clk_on_nx;
      gated_q  <= gated_nx;
    end
  end

  // The NAND input is a flop, ORed only with the scan-static override.
  assign clken  = clken_q | ovrd;
  assign clk_on = clk_on_q;
  assign gated  = gated_q;

endmodule
